dice_match_controller: RTL and testbench

Sequences the dice-game FSM for a two-player match. Conditions the raw roll pushbutton into single-cycle roll pulses and resets the game FSM between rounds. Alternates turns between two players, tallies round wins, and declares a match winner at a target score. Sits between the board I/O and the game FSM; the FSM's win/loss LEDs feed back into it.

---
 rtl/dice_pkg.sv | 23 ++
 rtl/button_debouncer.sv | 61 ++++++
 rtl/dice_match_controller.sv | 136 +++++++++++++
 tb/tb_dice_match_controller.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dice_pkg
//  Description : Shared types and constants for the dice match controller.
//  Revision    : 1.0  initial release
// ============================================================================
package dice_pkg;

   localparam int SCORE_W = 4;

   localparam logic P1 = 1'b0;
   localparam logic P2 = 1'b1;

   typedef enum logic [2:0] {
      INIT   = 3'd0,
      PLAY   = 3'd1,
      RESULT = 3'd2,
      CLEAR  = 3'd3,
      DONE   = 3'd4
   } match_state_t;

endpackage
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : button_debouncer
//  Description : Synchronizes an active-low bouncy pushbutton, debounces it
//                and emits a one-cycle pulse on each debounced press.
//  Revision    : 1.0  initial release
// ============================================================================
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clock,
   input  logic reset,
   input  logic btn_n,
   output logic press
);

   localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

   logic        sync1_q, sync1_d;
   logic        sync2_q, sync2_d;
   logic        level_q, level_d;
   logic [15:0] cnt_q,   cnt_d;
   logic        press_q, press_d;

   // Synchronize, count consecutive differing samples, and detect the 1->0 edge.
   always_comb begin
      sync1_d = btn_n;
      sync2_d = sync1_q;
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_MAX) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 16'd1;
         end
      end
      press_d = level_q & ~level_d;
   end

   // State registers; reset leaves the button in the released state.
   always_ff @(posedge clock) begin
      if (!reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press = press_q;

endmodule
`default_nettype wire

// File: rtl/dice_match_controller.sv
`default_nettype none
// ============================================================================
//  Module      : dice_match_controller
//  Description : Two-player match sequencer around the dice game FSM: roll
//                pulses, turn alternation, round tallies and match winner.
//  Revision    : 1.0  initial release
// ============================================================================
module dice_match_controller
   import dice_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int WIN_TARGET      = 3
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               roll_n,
   input  logic               game_win,
   input  logic               game_loss,
   output logic               game_roll,
   output logic               game_rst_n,
   output logic               player,
   output logic [SCORE_W-1:0] score1,
   output logic [SCORE_W-1:0] score2,
   output logic               match_over,
   output logic               winner
);

   localparam logic [SCORE_W-1:0] TARGET = SCORE_W'(WIN_TARGET);

   match_state_t       state_q, state_d;
   logic               player_q, player_d;
   logic [SCORE_W-1:0] score1_q, score1_d;
   logic [SCORE_W-1:0] score2_q, score2_d;
   logic               winner_q, winner_d;
   logic               game_roll_q, game_roll_d;
   logic               game_rst_n_q, game_rst_n_d;
   logic               match_over_q, match_over_d;

   logic               press;
   logic               outcome;
   logic               round_won;
   logic [SCORE_W-1:0] cur_score;
   logic [SCORE_W-1:0] next_score;

   button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_roll_db (
      .clock (clock),
      .reset (reset),
      .btn_n (roll_n),
      .press (press)
   );

   // Next-state and registered-output logic; an outcome takes priority over a press.
   always_comb begin
      state_d      = state_q;
      player_d     = player_q;
      score1_d     = score1_q;
      score2_d     = score2_q;
      winner_d     = winner_q;
      game_roll_d  = 1'b0;
      outcome      = game_win | game_loss;
      round_won    = game_win & ~game_loss;
      cur_score    = (player_q == P1) ? score1_q : score2_q;
      next_score   = (cur_score < TARGET) ? cur_score + {{(SCORE_W-1){1'b0}}, 1'b1} : cur_score;

      unique case (state_q)
         INIT: state_d = PLAY;
         PLAY: begin
            if (outcome) begin
               state_d = RESULT;
               if (round_won) begin
                  if (player_q == P1) score1_d = next_score;
                  else                score2_d = next_score;
                  if (next_score == TARGET) begin
                     state_d  = DONE;
                     winner_d = player_q;
                  end
               end
            end else if (press) begin
               game_roll_d = 1'b1;
            end
         end
         RESULT: if (press) state_d = CLEAR;
         CLEAR: begin
            player_d = ~player_q;
            state_d  = PLAY;
         end
         DONE: begin
            if (press) begin
               state_d  = CLEAR;
               score1_d = '0;
               score2_d = '0;
               player_d = P2;   // toggled back to P1 on the way out of CLEAR
            end
         end
         default: state_d = INIT;
      endcase

      game_rst_n_d = !((state_d == INIT) || (state_d == CLEAR));
      match_over_d = (state_d == DONE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= INIT;
         player_q     <= P1;
         score1_q     <= '0;
         score2_q     <= '0;
         winner_q     <= 1'b0;
         game_roll_q  <= 1'b0;
         game_rst_n_q <= 1'b0;
         match_over_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         player_q     <= player_d;
         score1_q     <= score1_d;
         score2_q     <= score2_d;
         winner_q     <= winner_d;
         game_roll_q  <= game_roll_d;
         game_rst_n_q <= game_rst_n_d;
         match_over_q <= match_over_d;
      end
   end

   assign game_roll  = game_roll_q;
   assign game_rst_n = game_rst_n_q;
   assign player     = player_q;
   assign score1     = score1_q;
   assign score2     = score2_q;
   assign match_over = match_over_q;
   assign winner     = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_dice_match_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dice_match_controller
//  Description : Scoreboard bench for dice_match_controller (debounce 4,
//                target 2).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dice_match_controller;

   logic       clock     = 1'b0;
   logic       reset     = 1'b0;
   logic       roll_n    = 1'b1;
   logic       game_win  = 1'b0;
   logic       game_loss = 1'b0;
   wire        game_roll;
   wire        game_rst_n;
   wire        player;
   wire  [3:0] score1;
   wire  [3:0] score2;
   wire        match_over;
   wire        winner;

   dice_match_controller #(
      .DEBOUNCE_CYCLES(4),
      .WIN_TARGET     (2)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .roll_n     (roll_n),
      .game_win   (game_win),
      .game_loss  (game_loss),
      .game_roll  (game_roll),
      .game_rst_n (game_rst_n),
      .player     (player),
      .score1     (score1),
      .score2     (score2),
      .match_over (match_over),
      .winner     (winner)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [11:0] vec;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   roll_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // {player, score1, score2, match_over, winner, game_rst_n}
   function automatic logic [11:0] v(input bit p, input int s1, input int s2,
                                     input bit mo, input bit w, input bit rn);
      return {p, 4'(s1), 4'(s2), mo, w, rn};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_at(input int c, input logic [11:0] vec, input string name);
      exp_t e;
      e.cyc  = c;
      e.vec  = vec;
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic expect_now(input logic [11:0] vec, input string name);
      expect_at(cyc, vec, name);
   endtask

   // Press and hold the button long enough to debounce, then release it.
   // The press takes effect in the controller 7 cycles after it starts.
   task automatic do_press(input bit exp_roll, input bit has_mid,
                           input logic [11:0] mid, input logic [11:0] after,
                           input string name);
      int c0;
      c0 = cyc;
      if (exp_roll) roll_q.push_back(c0 + 7);
      if (has_mid) begin
         expect_at(c0 + 7, mid,   {name, "_clear"});
         expect_at(c0 + 8, after, {name, "_play"});
      end
      roll_n = 1'b0;
      repeat (8) tick();
      roll_n = 1'b1;
      repeat (8) tick();
   endtask

   task automatic outcome(input bit w, input bit l);
      game_win  = w;
      game_loss = l;
      tick();
      game_win  = 1'b0;
      game_loss = 1'b0;
   endtask

   // Monitor: compares scoreboard entries and every game_roll pulse.
   initial begin
      logic [11:0] got;
      forever begin
         @(negedge clock);
         got = {player, score1, score2, match_over, winner, game_rst_n};
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            n_checks++;
            $display("FAIL %s: not sampled at cycle %0d (now %0d)", sb[0].name, sb[0].cyc, cyc);
            void'(sb.pop_front());
         end
         if (sb.size() > 0 && sb[0].cyc == cyc) begin
            n_checks++;
            if (got === sb[0].vec) n_pass++;
            else $display("FAIL %s: cycle %0d got %03h want %03h (p,s1,s2,mo,w,rst_n)",
                          sb[0].name, cyc, got, sb[0].vec);
            void'(sb.pop_front());
         end
         while (roll_q.size() > 0 && roll_q[0] < cyc) begin
            n_checks++;
            $display("FAIL roll_missing: game_roll not seen at cycle %0d (got 0 want 1)", roll_q[0]);
            void'(roll_q.pop_front());
         end
         if (game_roll === 1'b1) begin
            n_checks++;
            if (roll_q.size() > 0 && roll_q[0] == cyc) begin
               n_pass++;
               void'(roll_q.pop_front());
            end else begin
               $display("FAIL roll_unexpected: game_roll at cycle %0d (got 1 want 0)", cyc);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL timeout: bench did not finish (got running want done)");
      $fatal(1, "timeout");
   end

   // Directed stimulus.
   initial begin
      int c0;
      tick();
      expect_now(v(0,0,0,0,0,0), "reset_values");
      tick();
      reset = 1'b1;
      tick();
      expect_now(v(0,0,0,0,0,1), "init_to_play");

      // Bounce rejection, then a clean long press.
      repeat (5) begin
         roll_n = 1'b0; repeat (2) tick();
         roll_n = 1'b1; repeat (2) tick();
      end
      c0 = cyc;
      roll_q.push_back(c0 + 7);
      roll_n = 1'b0;
      repeat (10) tick();
      roll_n = 1'b1;
      repeat (8) tick();

      // Round win for P1, then the clearing press.
      do_press(1'b1, 1'b0, '0, '0, "roll_play");
      outcome(1'b1, 1'b0);
      expect_now(v(0,1,0,0,0,1), "p1_round_win");
      do_press(1'b0, 1'b1, v(0,1,0,0,0,0), v(1,1,0,0,0,1), "result_press");

      // Loss, then win+loss conflict.
      outcome(1'b0, 1'b1);
      expect_now(v(1,1,0,0,0,1), "p2_loss");
      do_press(1'b0, 1'b1, v(1,1,0,0,0,0), v(0,1,0,0,0,1), "after_loss");
      outcome(1'b1, 1'b1);
      expect_now(v(0,1,0,0,0,1), "win_loss_conflict");
      do_press(1'b0, 1'b1, v(0,1,0,0,0,0), v(1,1,0,0,0,1), "after_conflict");

      // Press and win land on the same cycle: no roll, one increment.
      roll_n = 1'b0;
      repeat (6) tick();
      game_win = 1'b1;
      tick();
      game_win = 1'b0;
      expect_now(v(1,1,1,0,0,1), "press_and_win");
      tick();
      roll_n = 1'b1;
      repeat (8) tick();

      // Reset in RESULT with score2 = 1.
      reset = 1'b0;
      tick();
      expect_now(v(0,0,0,0,0,0), "mid_reset");
      reset = 1'b1;
      tick();
      expect_now(v(0,0,0,0,0,1), "mid_reset_play");

      // P1 takes the match.
      outcome(1'b1, 1'b0);
      expect_now(v(0,1,0,0,0,1), "m1_p1_win");
      do_press(1'b0, 1'b1, v(0,1,0,0,0,0), v(1,1,0,0,0,1), "m1_clr1");
      outcome(1'b0, 1'b1);
      expect_now(v(1,1,0,0,0,1), "m1_p2_loss");
      do_press(1'b0, 1'b1, v(1,1,0,0,0,0), v(0,1,0,0,0,1), "m1_clr2");
      outcome(1'b1, 1'b0);
      expect_now(v(0,2,0,1,0,1), "m1_done");
      outcome(1'b1, 1'b0);
      expect_now(v(0,2,0,1,0,1), "done_holds");
      do_press(1'b0, 1'b1, v(1,0,0,0,0,0), v(0,0,0,0,0,1), "done_restart");
      do_press(1'b1, 1'b0, '0, '0, "roll_after_restart");

      // P2 takes the next match.
      outcome(1'b0, 1'b1);
      expect_now(v(0,0,0,0,0,1), "m2_p1_loss");
      do_press(1'b0, 1'b1, v(0,0,0,0,0,0), v(1,0,0,0,0,1), "m2_clr1");
      outcome(1'b1, 1'b0);
      expect_now(v(1,0,1,0,0,1), "m2_p2_win");
      do_press(1'b0, 1'b1, v(1,0,1,0,0,0), v(0,0,1,0,0,1), "m2_clr2");
      outcome(1'b0, 1'b1);
      expect_now(v(0,0,1,0,0,1), "m2_p1_loss2");
      do_press(1'b0, 1'b1, v(0,0,1,0,0,0), v(1,0,1,0,0,1), "m2_clr3");
      outcome(1'b1, 1'b0);
      expect_now(v(1,0,2,1,1,1), "m2_done_p2");

      repeat (10) tick();
      if (sb.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
      end
      if (roll_q.size() != 0) begin
         n_checks++;
         $display("FAIL roll_drain: got %0d rolls pending want 0", roll_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
